// File: rtl/float_point_div_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
// Word layout is {sign, exp[EXP_LEN], mantissa[MANTISSA_LEN]} with a hidden leading 1.
package float_point_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Exponent bias for a given exponent width.
  function automatic int fp_bias(input int expLen);
    return (1 << (expLen - 1)) - 1;
  endfunction

  // Number of quotient bits produced: hidden bit, mantissa, guard and one extra
  // bit so normalisation never runs short.
  function automatic int fp_qbits(input int mantLen);
    return mantLen + 3;
  endfunction

  // The helpers take the word zero-extended to 64 bits so one function serves
  // any format; callers size-cast the result back down.
  function automatic logic fp_sign(input logic [63:0] word, input int expLen, input int mantLen);
    return word[expLen + mantLen];
  endfunction

  function automatic logic [63:0] fp_exp(input logic [63:0] word, input int expLen, input int mantLen);
    return (word >> mantLen) & ((64'd1 << expLen) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_mant(input logic [63:0] word, input int mantLen);
    return word & ((64'd1 << mantLen) - 64'd1);
  endfunction

  // Zero means exponent and mantissa both clear; the sign bit does not matter.
  function automatic logic fp_is_zero(input logic [63:0] word, input int expLen, input int mantLen);
    return (word & ((64'd1 << (expLen + mantLen)) - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/float_point_div_iter.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module float_point_div_iter #(
  parameter int MANTISSA_LEN = 23
) (
  input  logic [MANTISSA_LEN+1:0] rem_i,
  input  logic [MANTISSA_LEN:0]   mb_i,
  output logic [MANTISSA_LEN+1:0] rem_o,
  output logic                    qbit_o
);

  logic [MANTISSA_LEN+1:0] mbExt;
  logic [MANTISSA_LEN+1:0] diff;

  // The remainder is always below mb after a step, so the shift never drops a set bit.
  always_comb begin
    mbExt  = {1'b0, mb_i};
    qbit_o = (rem_i >= mbExt);
    diff   = qbit_o ? (rem_i - mbExt) : rem_i;
    rem_o  = diff << 1;
  end

endmodule

// File: rtl/float_point_divider.sv
// Iterative floating-point divider, output_quotient = input_a / input_b.
// One quotient bit per clock, valid/ready on both sides, one operation in flight.
// Build option FPDIV_ROUND_EN: round-to-nearest-even; otherwise the result is truncated.
module float_point_divider
  import float_point_div_pkg::*;
#(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   input_a,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   input_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   output_quotient,
  output logic                            div_by_zero
);

  localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
  localparam int N     = fp_qbits(MANTISSA_LEN);
  localparam int BIAS  = fp_bias(EXP_LEN);
  localparam int CNT_W = $clog2(N + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            opA_q, opA_d;
  logic [W-1:0]            opB_q, opB_d;
  logic [MANTISSA_LEN+1:0] rem_q, rem_d;
  logic [MANTISSA_LEN:0]   mb_q, mb_d;
  logic [N-1:0]            quot_q, quot_d;
  logic [EXP_LEN-1:0]      exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic                    aZero_q, aZero_d;
  logic                    bZero_q, bZero_d;
  logic [W-1:0]            result_q, result_d;
  logic                    dbz_q, dbz_d;

  logic                    signA, signB, zeroA, zeroB;
  logic [EXP_LEN-1:0]      expA, expB, expDiff;
  logic [MANTISSA_LEN-1:0] mantA, mantB;

  logic [MANTISSA_LEN+1:0] remNext;
  logic                    qBit;

  logic [MANTISSA_LEN-1:0] mantNorm, mantRound;
  logic [EXP_LEN-1:0]      expNorm, expRound;
  logic                    guardBit, stickyBit, roundUp, mantCarry;

  assign signA   = fp_sign(64'(opA_q), EXP_LEN, MANTISSA_LEN);
  assign signB   = fp_sign(64'(opB_q), EXP_LEN, MANTISSA_LEN);
  assign zeroA   = fp_is_zero(64'(opA_q), EXP_LEN, MANTISSA_LEN);
  assign zeroB   = fp_is_zero(64'(opB_q), EXP_LEN, MANTISSA_LEN);
  assign expA    = EXP_LEN'(fp_exp(64'(opA_q), EXP_LEN, MANTISSA_LEN));
  assign expB    = EXP_LEN'(fp_exp(64'(opB_q), EXP_LEN, MANTISSA_LEN));
  assign mantA   = MANTISSA_LEN'(fp_mant(64'(opA_q), MANTISSA_LEN));
  assign mantB   = MANTISSA_LEN'(fp_mant(64'(opB_q), MANTISSA_LEN));
  assign expDiff = expA - expB + EXP_LEN'(BIAS);

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == HOLD);
  assign output_quotient = result_q;
  assign div_by_zero     = dbz_q;

  float_point_div_iter #(
    .MANTISSA_LEN(MANTISSA_LEN)
  ) u_iter (
    .rem_i  (rem_q),
    .mb_i   (mb_q),
    .rem_o  (remNext),
    .qbit_o (qBit)
  );

  // Normalise the raw quotient on its top bit and pick out guard and sticky.
  always_comb begin
    mantNorm  = '0;
    expNorm   = exp_q;
    guardBit  = 1'b0;
    stickyBit = 1'b0;
    if (quot_q[N-1]) begin
      mantNorm  = quot_q[N-2:2];
      guardBit  = quot_q[1];
      stickyBit = quot_q[0] | (|rem_q);
      expNorm   = exp_q;
    end else begin
      mantNorm  = quot_q[N-3:1];
      guardBit  = quot_q[0];
      stickyBit = |rem_q;
      expNorm   = exp_q - EXP_LEN'(1);
    end
  end

`ifdef FPDIV_ROUND_EN
  assign roundUp = guardBit & (stickyBit | mantNorm[0]);
`else
  logic unusedTruncBits;
  assign roundUp         = 1'b0;
  assign unusedTruncBits = guardBit ^ stickyBit;
`endif

  // A mantissa carry-out wraps the mantissa to zero and bumps the exponent.
  always_comb begin
    {mantCarry, mantRound} = {1'b0, mantNorm} + (MANTISSA_LEN + 1)'(roundUp);
    expRound               = expNorm + EXP_LEN'(mantCarry);
  end

  // Next-state logic: accept, set up, iterate, normalise, then hold for the consumer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quot_d   = quot_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    aZero_d  = aZero_q;
    bZero_d  = bZero_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = input_a;
          opB_d   = input_b;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt_q == '0) begin
          rem_d   = {1'b0, 1'b1, mantA};
          mb_d    = {1'b1, mantB};
          exp_d   = expDiff;
          sign_d  = signA ^ signB;
          aZero_d = zeroA;
          bZero_d = zeroB;
          quot_d  = '0;
        end else begin
          rem_d  = remNext;
          quot_d = {quot_q[N-2:0], qBit};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (aZero_q) begin
          result_d = '0;
          dbz_d    = 1'b0;
        end else if (bZero_q) begin
          result_d = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
          dbz_d    = 1'b1;
        end else begin
          result_d = {sign_q, expRound, mantRound};
          dbz_d    = 1'b0;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      quot_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      aZero_q  <= 1'b0;
      bZero_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quot_q   <= quot_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      aZero_q  <= aZero_d;
      bZero_q  <= bZero_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_float_point_divider.sv
// Directed bench for float_point_divider at the default single-precision format.
module tb_float_point_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        div_by_zero;
  logic [31:0] output_quotient;

  int vectorCount = 0;
  int missCount = 0;

`ifdef FPDIV_ROUND_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  float_point_divider dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .input_a         (input_a),
    .input_b         (input_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .output_quotient (output_quotient),
    .div_by_zero     (div_by_zero)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents operands, sees them accepted, then scrambles the inputs.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    input_a  = 32'hDEADBEEF;
    input_b  = 32'h12345678;
  endtask

  // Counts edges after the accept edge until out_valid, then checks the result.
  task automatic waitResult(input string tag, input logic [31:0] expQ, input logic expDbz);
    int edges = 0;
    while (out_valid !== 1'b1 && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'(28));
    checkOutput({tag, "_quotient"}, 64'(output_quotient), 64'(expQ));
    checkOutput({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(expDbz));
  endtask

  // Holds off the consumer for a while, then takes the result.
  task automatic consume(input int holdCycles, input logic [31:0] expQ);
    repeat (holdCycles) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_out_valid", 64'(out_valid), 64'(1));
      checkOutput("hold_quotient", 64'(output_quotient), 64'(expQ));
      checkOutput("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("consumed_out_valid", 64'(out_valid), 64'(0));
    checkOutput("consumed_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int spurious = 0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_quotient", 64'(output_quotient), 64'(0));
    checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'(0));

    $display("[TB] 6.0 / 2.0");
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResult("six_by_two", 32'h40400000, 1'b0);
    consume(0, 32'h40400000);

    $display("[TB] -7.5 / 2.5");
    applyStimulus(32'hC0F00000, 32'h40200000);
    waitResult("neg_seven_half", 32'hC0400000, 1'b0);
    consume(0, 32'hC0400000);

    $display("[TB] 1.0 / 3.0");
    applyStimulus(32'h3F800000, 32'h40400000);
    waitResult("one_third", ONE_THIRD, 1'b0);
    consume(0, ONE_THIRD);

    $display("[TB] 1.0 / 0.0");
    applyStimulus(32'h3F800000, 32'h00000000);
    waitResult("by_zero", 32'h7F800000, 1'b1);
    consume(0, 32'h7F800000);

    $display("[TB] -0.0 / 2.0");
    applyStimulus(32'h80000000, 32'h40000000);
    waitResult("zero_dividend", 32'h00000000, 1'b0);
    consume(0, 32'h00000000);

    $display("[TB] backpressure with a queued request");
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResult("bp_first", 32'h40400000, 1'b0);
    input_a  = 32'hC0F00000;
    input_b  = 32'h40200000;
    in_valid = 1'b1;
    consume(5, 32'h40400000);
    applyStimulus(32'hC0F00000, 32'h40200000);
    waitResult("bp_second", 32'hC0400000, 1'b0);
    consume(0, 32'hC0400000);

    $display("[TB] reset in the middle of a division");
    applyStimulus(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
    checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
    repeat (35) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) spurious++;
    end
    checkOutput("abort_no_spurious_result", 64'(spurious), 64'(0));
    applyStimulus(32'h40C00000, 32'h40000000);
    waitResult("after_abort", 32'h40400000, 1'b0);
    consume(0, 32'h40400000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
